// File: rtl/hazard_ctl.sv
// ---------------------------------------------------------------------------
// hazard_ctl
//
// Pipeline sequencing controller for the 5-stage CPU. Drives the 2-bit
// control code of the PC register and of the IF/ID, ID/EX and EX/MEM
// pipeline registers. The code is shared by all stage registers:
// 0 = load, 1 = hold, 2 = flush (clear to bubble). Code 3 is never driven.
//
// Hazards are resolved by priority:
//   1. memory wait       - freeze everything
//   2. taken redirect    - squash IF/ID and ID/EX
//   3. load-use          - insert one bubble
//   4. mult/div in EX    - hold the front end for MD_LAT-1 cycles
//
// Parameters:
//   MD_LAT  total EX-stage cycles of a mult/div op (1..15, 1 = no stall)
//   CNT_W   width of the mult/div busy counter
//   PERF_W  width of the performance counters
//
// Ports:
//   clk         system clock, rising edge
//   Reset       synchronous active-high reset
//   mem_wait    memory not ready, freeze pipeline
//   br_taken    branch/jump in EX resolved taken
//   ex_memread  instruction in EX is a load
//   ex_rd       destination register of the EX instruction
//   id_rs/id_rt source register fields of the ID instruction
//   id_use_rs/id_use_rt  ID instruction actually reads rs/rt
//   id_md       ID instruction is mult/div
//   pc_ctl, ifid_ctl, idexe_ctl, exmem_ctl  stage register controls
//   md_busy     controller is in the MD_BUSY state
//   stall_cnt   stall cycle count (HAZ_PERF_CNT_EN only, else 0)
//   flush_cnt   redirect flush count (HAZ_PERF_CNT_EN only, else 0)
//
// Optional feature macro: HAZ_PERF_CNT_EN enables the performance counters.
// ---------------------------------------------------------------------------
module hazard_ctl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              mem_wait,
    input  logic              br_taken,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_md,
    output logic [1:0]        pc_ctl,
    output logic [1:0]        ifid_ctl,
    output logic [1:0]        idexe_ctl,
    output logic [1:0]        exmem_ctl,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam logic [1:0] CTL_LOAD  = 2'd0;
    localparam logic [1:0] CTL_HOLD  = 2'd1;
    localparam logic [1:0] CTL_FLUSH = 2'd2;

    // The counter is loaded with MD_LAT-2 so that counting down to zero and
    // then leaving takes exactly MD_LAT-1 busy cycles.
    localparam logic [CNT_W-1:0] MD_INIT = (MD_LAT > 1) ? CNT_W'(MD_LAT - 2) : '0;

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             redirect;
    logic             md_start;

    // Load-use hazard: the EX load writes a register the ID instruction
    // really reads. Register $0 is hard-wired, so it never creates a hazard.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

    // A redirect or a load-use bubble squashes the ID instruction, so a
    // mult/div sitting in ID must not start in those cycles.
    assign redirect = (state == RUN) && !mem_wait && br_taken;
    assign md_start = (state == RUN) && !mem_wait && !br_taken && !load_use &&
                      id_md && (MD_LAT > 1);

    // Stage controls are purely combinational from state and inputs so the
    // pipeline reacts in the same cycle a hazard appears. Reset outranks
    // everything and fills the pipe with bubbles while holding the PC.
    always_comb begin
        pc_ctl    = CTL_LOAD;
        ifid_ctl  = CTL_LOAD;
        idexe_ctl = CTL_LOAD;
        exmem_ctl = CTL_LOAD;
        md_busy   = (state == MD_BUSY);
        if (Reset) begin
            pc_ctl    = CTL_HOLD;
            ifid_ctl  = CTL_FLUSH;
            idexe_ctl = CTL_FLUSH;
            exmem_ctl = CTL_FLUSH;
            md_busy   = 1'b0;
        end else if (mem_wait) begin
            pc_ctl    = CTL_HOLD;
            ifid_ctl  = CTL_HOLD;
            idexe_ctl = CTL_HOLD;
            exmem_ctl = CTL_HOLD;
        end else if (state == MD_BUSY) begin
            pc_ctl    = CTL_HOLD;
            ifid_ctl  = CTL_HOLD;
            idexe_ctl = CTL_HOLD;
            exmem_ctl = CTL_FLUSH;
        end else if (br_taken) begin
            ifid_ctl  = CTL_FLUSH;
            idexe_ctl = CTL_FLUSH;
        end else if (load_use) begin
            pc_ctl    = CTL_HOLD;
            ifid_ctl  = CTL_HOLD;
            idexe_ctl = CTL_FLUSH;
        end
    end

    // FSM and busy counter. mem_wait freezes both so the mult/div stall is
    // simply stretched by the memory wait cycles.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (!mem_wait) begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    // Performance counters: every non-reset cycle with a held PC is a stall,
    // every taken redirect in RUN is a flush. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_ctl == CTL_HOLD) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (redirect) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
